// File: rtl/timer_pkg.sv
// Shared types for the timer controller: FSM state and auto-reload mode encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between the register logic (master) and timer_ctrl (slave).
interface timer_ctrl_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  START;
  logic                  STOP;
  logic                  MODE;
  logic                  LOAD_EN;
  logic [WIDTH-1:0]      LOAD_VAL;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic [WIDTH-1:0]      Q;
  logic                  TICK;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output START, STOP, MODE, LOAD_EN, LOAD_VAL, PRESCALE,
    input  Q, TICK, BUSY, DONE
  );

  modport slave (
    input  START, STOP, MODE, LOAD_EN, LOAD_VAL, PRESCALE,
    output Q, TICK, BUSY, DONE
  );
endinterface

// File: rtl/tcount_core.sv
// Enabled up-counter built as a T-flip-flop chain with synchronous clear.
module tcount_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] t;

  // Bit i toggles when enabled and every lower bit is already 1.
  always_comb begin : toggle_chain
    logic carry;
    carry = EN;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & Q[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      Q <= '0;
    else if (CLR) Q <= '0;
    else          Q <= Q ^ t;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: start/stop FSM, prescaler, terminal-count register and
// one-shot / auto-reload sequencing around a tcount_core counter.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  timer_ctrl_if.slave  bus
);

  state_t                state, state_n;
  logic [PRESCALE_W-1:0] pcnt, pcnt_n;
  logic [WIDTH-1:0]      term, term_n;
  logic                  tick_r, tick_n;
  logic [WIDTH-1:0]      q;
  logic                  cnt_en, cnt_clr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      pcnt   <= '0;
      term   <= '1;
      tick_r <= 1'b0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      term   <= term_n;
      tick_r <= tick_n;
    end
  end

  // STOP outranks START, which outranks any step taken in RUN.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    term_n  = term;
    tick_n  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;

    if (bus.LOAD_EN && (state != ST_RUN))
      term_n = bus.LOAD_VAL;

    if (bus.STOP) begin
      state_n = ST_IDLE;
    end else if (bus.START) begin
      state_n = ST_RUN;
      pcnt_n  = '0;
      cnt_clr = 1'b1;
    end else if (state == ST_RUN) begin
      if (pcnt == bus.PRESCALE) begin
        pcnt_n = '0;
        if (q == term) begin
          tick_n = 1'b1;
          if (bus.MODE == MODE_PERIODIC) cnt_clr = 1'b1;
          else                           state_n = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end else begin
        pcnt_n = pcnt + PRESCALE_W'(1);
      end
    end
  end

  tcount_core #(.WIDTH(WIDTH)) u_count (
    .CLK (CLK),
    .RST (RST),
    .EN  (cnt_en),
    .CLR (cnt_clr),
    .Q   (q)
  );

  assign bus.Q    = q;
  assign bus.TICK = tick_r;
  assign bus.BUSY = (state == ST_RUN);
  assign bus.DONE = (state == ST_DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_timer_ctrl;

  localparam int W  = 4;
  localparam int PW = 4;
  localparam int QMOD = 1 << W;
  localparam int PMOD = 1 << PW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_ctrl_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural reference: plain integers, updated once per clock edge.
  int m_q, m_pcnt, m_term;
  bit m_run, m_done, m_tick;

  function automatic void model_reset();
    m_q = 0; m_pcnt = 0; m_term = QMOD - 1;
    m_run = 0; m_done = 0; m_tick = 0;
  endfunction

  function automatic void model_step();
    int nq, np, nt;
    bit nrun, ndone, ntick;
    nq = m_q; np = m_pcnt; nt = m_term;
    nrun = m_run; ndone = m_done; ntick = 0;
    if (bus.LOAD_EN && !m_run) nt = int'(bus.LOAD_VAL);
    if (bus.STOP) begin
      nrun = 0; ndone = 0;
    end else if (bus.START) begin
      nq = 0; np = 0; nrun = 1; ndone = 0;
    end else if (m_run) begin
      if (m_pcnt == int'(bus.PRESCALE)) begin
        np = 0;
        if (m_q == m_term) begin
          ntick = 1;
          if (bus.MODE) nq = 0;
          else begin nrun = 0; ndone = 1; end
        end else begin
          nq = (m_q + 1) % QMOD;
        end
      end else begin
        np = (m_pcnt + 1) % PMOD;
      end
    end
    m_q = nq; m_pcnt = np; m_term = nt;
    m_run = nrun; m_done = ndone; m_tick = ntick;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit st, input bit sp, input bit md, input bit le,
                       input int lv, input int pr);
    bus.START    = st;
    bus.STOP     = sp;
    bus.MODE     = md;
    bus.LOAD_EN  = le;
    bus.LOAD_VAL = W'(lv);
    bus.PRESCALE = PW'(pr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit st, sp, md, le;
    int lv, pr;
    int q, tick, busy, done;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit md, bit le, int lv, int pr,
                              int q, int tk, int by, int dn);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md; v.le = le; v.lv = lv; v.pr = pr;
    v.q = q; v.tick = tk; v.busy = by; v.done = dn;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // One-shot, term=3
    vt.push_back(mk(1,0,0,1,3,0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 1,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 3,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 3,1,0,1));
    vt.push_back(mk(0,0,0,0,0,0, 3,0,0,1));
    // STOP coinciding with the terminal step, term=4
    vt.push_back(mk(1,0,0,1,4,0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 1,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 3,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 4,0,1,0));
    vt.push_back(mk(0,1,0,0,0,0, 4,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0, 4,0,0,0));
    // STOP together with START stays idle
    vt.push_back(mk(1,1,0,0,0,0, 4,0,0,0));
    // LOAD with START applies; LOAD during RUN ignored
    vt.push_back(mk(1,0,0,1,3,0, 0,0,1,0));
    vt.push_back(mk(0,0,0,1,7,0, 1,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 2,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 3,0,1,0));
    vt.push_back(mk(0,0,0,0,0,0, 3,1,0,1));

    drive(0,0,0,0,0,0);
    model_reset();

    // Power-on reset
    #3;
    chk("rst_q",    int'(bus.Q),    0);
    chk("rst_tick", int'(bus.TICK), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_done", int'(bus.DONE), 0);
    #9 rst = 1'b0;

    // Directed table
    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].sp, vt[i].md, vt[i].le, vt[i].lv, vt[i].pr);
      cycle();
      chk($sformatf("vec%0d_q", i),    int'(bus.Q),    vt[i].q);
      chk($sformatf("vec%0d_tick", i), int'(bus.TICK), vt[i].tick);
      chk($sformatf("vec%0d_busy", i), int'(bus.BUSY), vt[i].busy);
      chk($sformatf("vec%0d_done", i), int'(bus.DONE), vt[i].done);
    end

    // Asynchronous reset in the middle of a run at Q=5
    drive(1,0,0,1,7,0);
    cycle();
    drive(0,0,0,0,0,0);
    for (int j = 0; j < 5; j++) cycle();
    chk("midrun_q_before", int'(bus.Q), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_q",    int'(bus.Q),    0);
    chk("arst_busy", int'(bus.BUSY), 0);
    chk("arst_tick", int'(bus.TICK), 0);
    chk("arst_done", int'(bus.DONE), 0);
    model_reset();
    #3 rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("postrst_q",    int'(bus.Q),    0);
      chk("postrst_tick", int'(bus.TICK), 0);
      chk("postrst_busy", int'(bus.BUSY), 0);
    end

    // Periodic, term=2, PRESCALE=1: Q steps every 2 cycles, TICK every 6
    drive(1,0,1,1,2,1);
    cycle();
    chk("per_q0", int'(bus.Q), 0);
    drive(0,0,1,0,0,1);
    for (int j = 1; j <= 18; j++) begin
      cycle();
      chk($sformatf("per_q_j%0d", j),    int'(bus.Q),    (j / 2) % 3);
      chk($sformatf("per_tick_j%0d", j), int'(bus.TICK), (j % 6 == 0) ? 1 : 0);
    end

    // term=0, PRESCALE=2: TICK every 3 cycles with Q pinned at 0
    drive(0,1,1,0,0,2);
    cycle();
    drive(1,0,1,1,0,2);
    cycle();
    drive(0,0,1,0,0,2);
    for (int j = 1; j <= 9; j++) begin
      cycle();
      chk($sformatf("t0_q_j%0d", j),    int'(bus.Q),    0);
      chk($sformatf("t0_tick_j%0d", j), int'(bus.TICK), (j % 3 == 0) ? 1 : 0);
    end

    // Restart mid-run at Q=2 with the prescaler part-way through
    drive(0,1,1,0,0,1);
    cycle();
    drive(1,0,1,1,5,1);
    cycle();
    drive(0,0,1,0,0,1);
    for (int j = 1; j <= 5; j++) cycle();
    chk("restart_q_before", int'(bus.Q), 2);
    drive(1,0,1,0,0,1);
    cycle();
    chk("restart_q0",   int'(bus.Q),    0);
    chk("restart_busy", int'(bus.BUSY), 1);
    drive(0,0,1,0,0,1);
    cycle();
    chk("restart_q1", int'(bus.Q), 0);
    cycle();
    chk("restart_q2", int'(bus.Q), 1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.START    = ($urandom_range(0, 99) < 6);
      bus.STOP     = ($urandom_range(0, 99) < 3);
      bus.MODE     = $urandom_range(0, 1) != 0;
      bus.LOAD_EN  = ($urandom_range(0, 99) < 12);
      bus.LOAD_VAL = W'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 8) bus.PRESCALE = PW'($urandom_range(0, 3));
      cycle();
      chk("rand_q",    int'(bus.Q),    m_q);
      chk("rand_tick", int'(bus.TICK), int'(m_tick));
      chk("rand_busy", int'(bus.BUSY), int'(m_run));
      chk("rand_done", int'(bus.DONE), int'(m_done));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
